// File: rtl/door_access_ctrl.sv
// ---------------------------------------------------------------------------
// door_access_ctrl
//   Single-door card access controller. When the entrance sensor fires, the
//   controller scans for a card, then grants access (door open for a fixed
//   time) or denies it (red for a fixed time). It counts consecutive wrong
//   cards and enters an alarmed lockout when too many arrive. An admin
//   unlock releases the lockout early.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-high, clears all state
//   sensor_entrance  person detected at the door (level)
//   card_present     one-cycle strobe qualifying card_valid
//   card_valid       card accepted by reader
//   admin_unlock     level, releases LOCKOUT
//   GREEN_LED        access granted
//   RED_LED          access denied / locked out
//   YELLOW_LED       waiting for card
//   door_status      1 = door open
//   ALARM            lockout alarm
//   wrong_count      consecutive wrong attempts (saturating)
//   state            debug view of the state register
// ---------------------------------------------------------------------------
module door_access_ctrl #(
  parameter int SCAN_CYCLES    = 8,
  parameter int OPEN_CYCLES    = 16,
  parameter int DENY_CYCLES    = 4,
  parameter int MAX_WRONG      = 3,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int TMR_W          = 16,
  parameter int WC_W           = $clog2(MAX_WRONG + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sensor_entrance,
  input  logic            card_present,
  input  logic            card_valid,
  input  logic            admin_unlock,
  output logic            GREEN_LED,
  output logic            RED_LED,
  output logic            YELLOW_LED,
  output logic            door_status,
  output logic            ALARM,
  output logic [WC_W-1:0] wrong_count,
  output logic [2:0]      state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SCAN    = 3'd1;
  localparam logic [2:0] ST_DENIED  = 3'd2;
  localparam logic [2:0] ST_GRANTED = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // Last timer value of each timed state: the state exits on this edge.
  localparam logic [TMR_W-1:0] SCAN_LAST = TMR_W'(SCAN_CYCLES - 1);
  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] DENY_LAST = TMR_W'(DENY_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_MAX    = WC_W'(MAX_WRONG);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [WC_W-1:0]  wc_inc;

  // Saturating increment; the count never wraps past MAX_WRONG.
  assign wc_inc = (wc_q >= WC_MAX) ? wc_q : wc_q + 1'b1;

  // State, timer and wrong-attempt registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wc_q    <= wc_d;
    end
  end

  // Next-state, next-timer and next-count logic
  always_comb begin
    state_d = ST_IDLE;
    wc_d    = wc_q;
    case (state_q)
      ST_IDLE: begin
        state_d = sensor_entrance ? ST_SCAN : ST_IDLE;
      end
      ST_SCAN: begin
        // A card strobe takes priority over the timeout on the same cycle.
        if (card_present && card_valid) begin
          state_d = ST_GRANTED;
          wc_d    = '0;
        end else if (card_present) begin
          wc_d    = wc_inc;
          state_d = (wc_inc >= WC_MAX) ? ST_LOCKOUT : ST_DENIED;
        end else if (timer_q == SCAN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DENIED: begin
        state_d = (timer_q == DENY_LAST) ? ST_IDLE : ST_DENIED;
      end
      ST_GRANTED: begin
        state_d = (timer_q == OPEN_LAST) ? ST_IDLE : ST_GRANTED;
      end
      ST_LOCKOUT: begin
        if (admin_unlock || (timer_q == LOCK_LAST)) begin
          state_d = ST_IDLE;
          wc_d    = '0;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timer restarts at zero on every state change and only counts while
    // staying in a timed state; IDLE holds it at zero.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Moore output decode
  always_comb begin
    GREEN_LED   = 1'b0;
    RED_LED     = 1'b0;
    YELLOW_LED  = 1'b0;
    door_status = 1'b0;
    ALARM       = 1'b0;
    case (state_q)
      ST_SCAN: begin
        YELLOW_LED = 1'b1;
      end
      ST_DENIED: begin
        RED_LED = 1'b1;
      end
      ST_GRANTED: begin
        GREEN_LED   = 1'b1;
        door_status = 1'b1;
      end
      ST_LOCKOUT: begin
        RED_LED = 1'b1;
        ALARM   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign wrong_count = wc_q;
  assign state       = state_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
module tb_door_access_ctrl;

  logic       clk;
  logic       reset;
  logic       sensor_entrance;
  logic       card_present;
  logic       card_valid;
  logic       admin_unlock;
  logic       GREEN_LED;
  logic       RED_LED;
  logic       YELLOW_LED;
  logic       door_status;
  logic       ALARM;
  logic [1:0] wrong_count;
  logic [2:0] state;

  int checks;
  int errors;

  door_access_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .card_present    (card_present),
    .card_valid      (card_valid),
    .admin_unlock    (admin_unlock),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .YELLOW_LED      (YELLOW_LED),
    .door_status     (door_status),
    .ALARM           (ALARM),
    .wrong_count     (wrong_count),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State codes and output patterns {GREEN, RED, YELLOW, door, ALARM}
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_DEN  = 3'd2;
  localparam logic [2:0] S_GRN  = 3'd3;
  localparam logic [2:0] S_LOCK = 3'd4;
  localparam logic [4:0] L_IDLE = 5'b00000;
  localparam logic [4:0] L_SCAN = 5'b00100;
  localparam logic [4:0] L_DEN  = 5'b01000;
  localparam logic [4:0] L_GRN  = 5'b10010;
  localparam logic [4:0] L_LOCK = 5'b01001;

  // One row: inputs held for n edges; after each edge the outputs must match.
  typedef struct {
    logic       sensor;
    logic       cp;
    logic       cv;
    logic       admin;
    int         n;
    logic [2:0] st;
    logic [4:0] leds;
    logic [1:0] wc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic cp, input logic cv, input logic ad,
                     input int n, input logic [2:0] st, input logic [4:0] l,
                     input logic [1:0] wc);
    vec_t v;
    v.sensor = s; v.cp = cp; v.cv = cv; v.admin = ad;
    v.n = n; v.st = st; v.leds = l; v.wc = wc;
    vq.push_back(v);
  endtask

  // Scan with a wrong card that leads to DENIED, then back to IDLE.
  task automatic add_wrong_denied(input logic [1:0] wc_before);
    add(1, 0, 0, 0, 1, S_SCAN, L_SCAN, wc_before);
    add(0, 1, 0, 0, 1, S_DEN,  L_DEN,  wc_before + 2'd1);
    add(0, 0, 0, 0, 3, S_DEN,  L_DEN,  wc_before + 2'd1);
    add(0, 0, 0, 0, 1, S_IDLE, L_IDLE, wc_before + 2'd1);
  endtask

  task automatic chk(input string nm, input int r, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d at %0t: got %0h expected %0h", nm, r, $time, got, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      sensor_entrance = vq[r].sensor;
      card_present    = vq[r].cp;
      card_valid      = vq[r].cv;
      admin_unlock    = vq[r].admin;
      for (int c = 0; c < vq[r].n; c++) begin
        @(posedge clk);
        #1;
        chk("state", r, {5'd0, state}, {5'd0, vq[r].st});
        chk("leds", r, {3'd0, GREEN_LED, RED_LED, YELLOW_LED, door_status, ALARM},
            {3'd0, vq[r].leds});
        chk("wrong_count", r, {6'd0, wrong_count}, {6'd0, vq[r].wc});
      end
    end
  endtask

  int split;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    sensor_entrance = 1'b0;
    card_present    = 1'b0;
    card_valid      = 1'b0;
    admin_unlock    = 1'b0;

    // ---- Part A vectors ----
    // Valid card on SCAN cycle 3, door open 16 cycles
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 2,  S_SCAN, L_SCAN, 0);
    add(0, 1, 1, 0, 1,  S_GRN,  L_GRN,  0);
    add(0, 0, 0, 0, 15, S_GRN,  L_GRN,  0);
    add(0, 0, 0, 0, 1,  S_IDLE, L_IDLE, 0);
    // Scan timeout after 8 cycles
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 7,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 1,  S_IDLE, L_IDLE, 0);
    // Timeout with sensor held high, IDLE lasts a single cycle
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 7,  S_SCAN, L_SCAN, 0);
    add(1, 0, 0, 0, 1,  S_IDLE, L_IDLE, 0);
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 7,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 1,  S_IDLE, L_IDLE, 0);
    // Lockout after three wrong cards; inputs ignored during lockout
    add_wrong_denied(0);
    add_wrong_denied(1);
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 2);
    add(0, 1, 0, 0, 1,  S_LOCK, L_LOCK, 3);
    add(1, 1, 1, 0, 31, S_LOCK, L_LOCK, 3);
    add(0, 0, 0, 0, 1,  S_IDLE, L_IDLE, 0);
    // Recovery: two wrong, then valid clears count, then one wrong
    add_wrong_denied(0);
    add_wrong_denied(1);
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 2);
    add(0, 1, 1, 0, 1,  S_GRN,  L_GRN,  0);
    add(0, 0, 0, 0, 15, S_GRN,  L_GRN,  0);
    add(0, 0, 0, 0, 1,  S_IDLE, L_IDLE, 0);
    add_wrong_denied(0);
    // Admin unlock at lockout cycle 5, then admin in IDLE has no effect
    add_wrong_denied(1);
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 2);
    add(0, 1, 0, 0, 1,  S_LOCK, L_LOCK, 3);
    add(0, 0, 0, 0, 4,  S_LOCK, L_LOCK, 3);
    add(0, 0, 0, 1, 1,  S_IDLE, L_IDLE, 0);
    add(0, 0, 0, 1, 2,  S_IDLE, L_IDLE, 0);
    // Card strobe on the timeout cycle wins
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 0);
    add(0, 0, 0, 0, 7,  S_SCAN, L_SCAN, 0);
    add(0, 1, 1, 0, 1,  S_GRN,  L_GRN,  0);
    add(0, 0, 0, 0, 5,  S_GRN,  L_GRN,  0);
    split = vq.size();
    // ---- Part B vectors (after the async reset) ----
    // Card in IDLE is discarded; card strobes during DENIED are ignored
    add(0, 1, 1, 0, 1,  S_IDLE, L_IDLE, 0);
    add(1, 0, 0, 0, 1,  S_SCAN, L_SCAN, 0);
    add(0, 1, 0, 0, 1,  S_DEN,  L_DEN,  1);
    add(0, 1, 0, 0, 1,  S_DEN,  L_DEN,  1);
    add(0, 1, 1, 0, 1,  S_DEN,  L_DEN,  1);
    add(0, 0, 0, 0, 1,  S_DEN,  L_DEN,  1);
    add(0, 0, 0, 0, 1,  S_IDLE, L_IDLE, 1);

    // Reset state, while asserted and just after release
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", -1, {5'd0, state}, 8'd0);
    chk("reset_leds", -1, {3'd0, GREEN_LED, RED_LED, YELLOW_LED, door_status, ALARM}, 8'd0);
    chk("reset_wc", -1, {6'd0, wrong_count}, 8'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_state", -1, {5'd0, state}, 8'd0);

    run_rows(0, split);

    // Async reset in the middle of GRANTED closes the door without a clock edge
    #3;
    reset = 1'b1;
    #1;
    chk("async_door", -2, {7'd0, door_status}, 8'd0);
    chk("async_state", -2, {5'd0, state}, 8'd0);
    chk("async_leds", -2, {3'd0, GREEN_LED, RED_LED, YELLOW_LED, door_status, ALARM}, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("async_hold_state", -2, {5'd0, state}, 8'd0);

    run_rows(split, vq.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
